instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Reader side of the 10-bit program ROM. Owns the PC and drives the ROM address.
//  Captures each combinational ROM word into an output register and hands it to decode
//  with a valid/ready handshake. Accepts branch/jump redirects from execute and stops
//  fetching on the HALT word.
// PARAMETERS
//  ADDR_W     10             ROM address width; PC wraps modulo 2**ADDR_W
//  DATA_W     10             instruction word width
//  RESET_PC   10'd1          first fetch address after reset (program starts at mem[1])
//  HALT_WORD  10'b0010000010 encoding that stops fetch
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  rom_address   out  ADDR_W  to ROM address; always equals internal pc
//  rom_read_data in   DATA_W  ROM word for rom_address, valid in the same cycle (async ROM)
//  instr         out  DATA_W  registered instruction to decode
//  instr_pc      out  ADDR_W  address instr was fetched from
//  instr_valid   out  1       instr/instr_pc hold a live instruction
//  instr_ready   in   1       decode accepts instr on a clk edge when valid&ready
//  redirect      in   1       one-cycle pulse: flush and restart fetch at redirect_pc
//  redirect_pc   in   ADDR_W  redirect target
//  resume        in   1       leave HALT and continue at halt address + 1
//  halted        out  1       HALT state entered and halt word already consumed
// BEHAVIOUR
//  - Reset (sync, priority over all): pc=RESET_PC, state=FETCH, instr=0, instr_pc=0,
//    instr_valid=0, halted=0. Asserting reset mid-operation discards everything in flight.
//  - States: FETCH, HALT. rom_address = pc, combinational from the pc register.
//  - Slot free = !instr_valid | instr_ready.
//  - FETCH, no redirect, slot free: instr<=rom_read_data, instr_pc<=pc, instr_valid<=1.
//      If word != HALT_WORD: pc<=pc+1 (ADDR_W-bit wrap, 1023->0).
//      If word == HALT_WORD: pc unchanged; state<=HALT.
//  - FETCH, slot not free (valid & !ready): instr, instr_pc, instr_valid and pc all hold.
//  - Latency: first instr_valid=1 one edge after reset deasserts. Sustained throughput is
//    one instruction per cycle while instr_ready=1.
//  - redirect=1 (any state): pc<=redirect_pc, instr_valid<=0, state<=FETCH, halted<=0.
//    No capture that cycle. The instruction at redirect_pc is valid on the following edge.
//    A held (stalled) instruction is dropped. redirect beats resume and the capture path.
//  - HALT: no captures. The halt word stays valid until accepted; then instr_valid<=0 and
//    halted<=1. halted = (state==HALT) & !instr_valid, registered.
//    resume=1 in HALT (no redirect): pc<=pc+1, state<=FETCH, halted<=0. If the halt word
//    is still unaccepted, resume is ignored. resume in FETCH is ignored.
//  - Simultaneous accept of the old instruction and capture of the new one on the same edge
//    is legal; there is no bubble.
// CONFIGURATION
//  NOP_SKIP_EN defined: an all-zero ROM word (padding/NOP) is never presented. On a capture
//    of 0, pc<=pc+1 and instr_valid<=0 (the slot was free), one bubble per zero word.
//    A zero word at redirect_pc is skipped the same way.
//  NOP_SKIP_EN undefined: zero words are presented like any other instruction.
// TESTING
//  1 ROM preloaded with the 11-word copy-loop program, ready=1, release reset ->
//    1 edge later valid=1, instr=1100110100, pc=1; then pc=2,3,4 on consecutive edges.
//  2 While instr_pc=4 is valid, ready=0 for 3 cycles -> instr=1101000100, instr_pc=4 and
//    rom_address=5 stay stable; ready=1 -> pc=5 presented on the next edge.
//  3 Pulse redirect with redirect_pc=4 while instr_pc=9 is valid -> next edge valid=0,
//    rom_address=4; the edge after that presents instr_pc=4, instr=1101000100.
//  4 Run to mem[11]=0010000010 -> presented once; after accept valid=0 and halted=1,
//    rom_address=11 held for 5 cycles; pulse resume -> halted=0, instr_pc=12 next edge.
//  5 Redirect to 1023 -> instr_pc=1023 then instr_pc=0 (wrap), with no stall.
//  6 Fetch mem[2..4] with mem[3]=0 -> NOP_SKIP_EN: pc 2, bubble, 4;
//    without NOP_SKIP_EN: pc 2,3,4 with instr=0 at pc 3.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: ROM read port, decode handshake and redirect/resume controls.
//   master : instr_fetch_unit side (drives rom_address, instr*, halted)
//   slave  : ROM + decode + execute side (drives rom_read_data, instr_ready,
//            redirect, redirect_pc, resume)
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_read_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              resume;
  logic              halted;

  modport master (
    output rom_address,
    input  rom_read_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_pc,
    input  resume,
    output halted
  );

  modport slave (
    input  rom_address,
    output rom_read_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_pc,
    output resume,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: reader side of the program ROM.
//   Owns the PC (rom_address = pc), registers each asynchronous ROM word into
//   instr/instr_pc and presents it to decode with instr_valid/instr_ready.
//   Redirects from execute flush and restart fetch; the HALT word stops fetch
//   until resume.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - instr_fetch_unit_if.master (ROM port, decode handshake, controls)
// Configuration:
//   NOP_SKIP_EN - when defined, all-zero ROM words are skipped instead of
//                 being presented (one bubble per zero word).
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(1),
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(10'b0010000010)
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [DATA_W-1:0] instr, instr_next;
  logic [ADDR_W-1:0] instr_pc, instr_pc_next;
  logic              instr_valid, instr_valid_next;
  logic              halted, halted_next;

  logic slot_free;
  logic is_halt_word;
  logic is_zero_word;

  assign slot_free    = !instr_valid || bus.instr_ready;
  assign is_halt_word = (bus.rom_read_data == HALT_WORD);
`ifdef NOP_SKIP_EN
  assign is_zero_word = (bus.rom_read_data == '0);
`else
  assign is_zero_word = 1'b0;
`endif

  // State register (also holds the datapath registers)
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr       <= instr_next;
      instr_pc    <= instr_pc_next;
      instr_valid <= instr_valid_next;
      halted      <= halted_next;
    end
  end

  // Next-state logic: redirect always returns to FETCH
  always_comb begin
    state_next = state;
    if (bus.redirect) begin
      state_next = S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: if (slot_free && !is_zero_word && is_halt_word) state_next = S_HALT;
        S_HALT:  if (!instr_valid && bus.resume)                 state_next = S_FETCH;
        default: state_next = S_FETCH;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    pc_next          = pc;
    instr_next       = instr;
    instr_pc_next    = instr_pc;
    instr_valid_next = instr_valid;
    halted_next      = halted;
    if (bus.redirect) begin
      // Redirect drops any held instruction and does not capture this cycle
      pc_next          = bus.redirect_pc;
      instr_valid_next = 1'b0;
      halted_next      = 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (slot_free) begin
            if (is_zero_word) begin
              pc_next          = pc + ADDR_W'(1);
              instr_valid_next = 1'b0;
            end else begin
              instr_next       = bus.rom_read_data;
              instr_pc_next    = pc;
              instr_valid_next = 1'b1;
              // pc parks on the halt word so resume continues at halt + 1
              if (!is_halt_word) pc_next = pc + ADDR_W'(1);
            end
          end
        end
        S_HALT: begin
          if (instr_valid) begin
            // resume is ignored until the halt word has been accepted
            if (bus.instr_ready) begin
              instr_valid_next = 1'b0;
              halted_next      = 1'b1;
            end
          end else if (bus.resume) begin
            pc_next     = pc + ADDR_W'(1);
            halted_next = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_address = pc;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.halted      = halted;

endmodule
